// File: rtl/sram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw_arbiter
// Purpose  : Two-requester (A/B) arbiter and command sequencer for the RW
//            port (port 0) of a 32x256 OpenRAM SRAM macro with byte masks.
//            Accepts single-word reads/writes over a req/gnt handshake,
//            drives the macro command from registers and returns read data
//            to the issuing requester two edges after acceptance.
// Ports    : clk, rst_n (async, active low)
//            a_*/b_*  : req, we, wmask, addr, wdata in; gnt, rvalid, rdata out
//            sram_*   : csb0, web0, wmask0, addr0, din0 out; dout0 in
// Config   : SRAM_ARB_FIXED_PRIO_EN defined -> A has strict priority over B
//            (no round-robin state). Undefined -> round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rw_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  // Owner encoding used by the response pipeline and the round-robin state.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // --------------------------------------------------------------------------
  // Arbitration. Grants are gated by rst_n so nothing is accepted in reset.
  // --------------------------------------------------------------------------
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign a_gnt = rst_n & a_req;
  assign b_gnt = rst_n & b_req & ~a_req;
`else
  // last_q remembers who was granted most recently; the other side wins a tie.
  logic last_q, last_d;

  assign a_gnt = rst_n & a_req & (~b_req | (last_q == OWNER_B));
  assign b_gnt = rst_n & b_req & (~a_req | (last_q == OWNER_A));

  always_comb begin
    last_d = last_q;
    if (a_gnt)      last_d = OWNER_A;
    else if (b_gnt) last_d = OWNER_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWNER_B;
    else        last_q <= last_d;
  end
`endif

  // --------------------------------------------------------------------------
  // Winner mux and registered macro command
  // --------------------------------------------------------------------------
  logic                  accept;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // gnt already implies req, so a grant on either side is an acceptance.
  assign accept    = a_gnt | b_gnt;
  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_wmask = b_gnt ? b_wmask : a_wmask;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;

  logic                  csb0_q,  csb0_d;
  logic                  web0_q,  web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q,  din0_d;

  // Read response pipeline: stage 1 = command issued, stage 2 = macro sampled.
  logic s1_valid_q, s1_valid_d, s1_owner_q, s1_owner_d;
  logic s2_valid_q, s2_valid_d, s2_owner_q, s2_owner_d;

  logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q,  a_rdata_d,  b_rdata_q,  b_rdata_d;

  always_comb begin
    // Idle cycle: deselect the macro but keep addr/din/wmask stable.
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (accept) begin
      csb0_d   = 1'b0;
      web0_d   = ~sel_we;
      wmask0_d = sel_we ? sel_wmask : '0;
      addr0_d  = sel_addr;
      din0_d   = sel_wdata;
    end

    s1_valid_d = accept & ~sel_we;
    s1_owner_d = b_gnt ? OWNER_B : OWNER_A;
    s2_valid_d = s1_valid_q;
    s2_owner_d = s1_owner_q;

    // Data was launched by the macro on the falling edge after stage 2 loaded.
    a_rvalid_d = s2_valid_q & (s2_owner_q == OWNER_A);
    b_rvalid_d = s2_valid_q & (s2_owner_q == OWNER_B);
    a_rdata_d  = a_rvalid_d ? sram_dout0 : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? sram_dout0 : b_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      wmask0_q   <= '0;
      addr0_q    <= '0;
      din0_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_owner_q <= OWNER_A;
      s2_valid_q <= 1'b0;
      s2_owner_q <= OWNER_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      csb0_q     <= csb0_d;
      web0_q     <= web0_d;
      wmask0_q   <= wmask0_d;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
      s1_valid_q <= s1_valid_d;
      s1_owner_q <= s1_owner_d;
      s2_valid_q <= s2_valid_d;
      s2_owner_q <= s2_owner_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rw_arbiter
// Purpose  : Directed self-checking bench for sram_rw_arbiter with a
//            behavioural model of the OpenRAM port-0 timing (command sampled
//            on the rising edge, write/read performed on the falling edge).
// Config   : honours SRAM_ARB_FIXED_PRIO_EN for the contention expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_rw_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [MW-1:0] a_wmask, b_wmask;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          sram_csb0, sram_web0;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // ---------------- SRAM macro model (port 0) ----------------
  logic [DW-1:0] mem [256];
  logic          m_csb, m_web;
  logic [MW-1:0] m_wmask;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    sram_dout0 = '0;
    m_csb = 1'b1;
    m_web = 1'b1;
    m_wmask = '0;
    m_addr = '0;
    m_din = '0;
  end

  always @(posedge clk) begin
    m_csb   <= sram_csb0;
    m_web   <= sram_web0;
    m_wmask <= sram_wmask0;
    m_addr  <= sram_addr0;
    m_din   <= sram_din0;
  end

  always @(negedge clk) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < MW; b++)
          if (m_wmask[b]) mem[m_addr][b*8 +: 8] = m_din[b*8 +: 8];
      end else begin
        sram_dout0 = mem[m_addr];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_wmask = wmask;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_wmask = wmask;
  endtask

  task automatic idle();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Winner of each contention cycle (0 = A, 1 = B) and its read data.
  logic          win_b [6];
  logic [DW-1:0] win_data [6];

  initial begin
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
    drive_b(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);

    // ---------------- reset ----------------
    step(); step(); step();
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_csb0", sram_csb0, 1);
    check("rst_web0", sram_web0, 1);
    check("rst_wmask0", sram_wmask0, 0);
    check("rst_addr0", sram_addr0, 0);
    check("rst_rvalids", {a_rvalid, b_rvalid}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    rst_n = 1'b1;
    #1;
    check("first_tie_a_gnt", a_gnt, 1);
    check("first_tie_b_gnt", b_gnt, 0);
    idle();
    step();

    // ---------------- single write then read ----------------
    drive_a(1'b1, 1'b1, 8'h12, 32'hDEADBEEF, 4'hF);
    #1 check("wr_a_gnt", a_gnt, 1);
    step();
    check("wr_cmd", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b0, 4'hF, 8'h12});
    check("wr_din", sram_din0, 32'hDEADBEEF);
    drive_a(1'b1, 1'b0, 8'h12, 32'h0, 4'hF);
    #1 check("rd_a_gnt", a_gnt, 1);
    step();
    check("rd_cmd", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b1, 4'h0, 8'h12});
    idle();
    step();
    check("rd_idle_csb0", {sram_csb0, sram_web0}, 2'b11);
    check("rd_addr_hold", sram_addr0, 8'h12);
    check("rd_rvalid_early", {a_rvalid, b_rvalid}, 2'b00);
    step();
    check("rd_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    check("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    step();
    check("rd_rvalid_pulse", {a_rvalid, b_rvalid}, 2'b00);
    check("rd_rdata_hold", a_rdata, 32'hDEADBEEF);

    // ---------------- byte mask ----------------
    drive_a(1'b1, 1'b1, 8'h05, 32'h11223344, 4'hF);
    step();
    drive_a(1'b1, 1'b1, 8'h05, 32'hAABBCCDD, 4'h5);
    step();
    drive_a(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    step();
    idle();
    step(); step();
    check("mask_rvalid", a_rvalid, 1);
    check("mask_rdata", a_rdata, 32'h11BB33DD);
    // all-zero mask write must reach the macro and leave memory untouched
    drive_a(1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 4'h0);
    step();
    check("zmask_cmd", {sram_csb0, sram_web0, sram_wmask0}, {1'b0, 1'b0, 4'h0});
    drive_a(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    step();
    idle();
    step(); step();
    check("zmask_rdata", a_rdata, 32'h11BB33DD);

    // ---------------- contention (fresh reset so last = B) ----------------
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem[8'h30 + i] = 32'hA0000000 + i;
      mem[8'h40 + i] = 32'hB0000000 + i;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      win_b[i] = 1'b0;
`else
      win_b[i] = (i % 2) == 1;
`endif
      win_data[i] = win_b[i] ? (32'hB0000000 + i) : (32'hA0000000 + i);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        drive_a(1'b1, 1'b0, 8'(8'h30 + i), 32'h0, 4'h0);
        drive_b(1'b1, 1'b0, 8'(8'h40 + i), 32'h0, 4'h0);
        #1 check($sformatf("cont_gnt%0d", i), {a_gnt, b_gnt}, {~win_b[i], win_b[i]});
      end else begin
        idle();
      end
      step();
      if (i >= 2) begin
        check($sformatf("cont_rv%0d", i - 2), {a_rvalid, b_rvalid}, {~win_b[i-2], win_b[i-2]});
        check($sformatf("cont_rd%0d", i - 2), win_b[i-2] ? b_rdata : a_rdata, win_data[i-2]);
      end
    end

    // ---------------- back-to-back B reads ----------------
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        drive_b(1'b1, 1'b0, 8'(i), 32'h0, 4'h0);
        #1 check($sformatf("b2b_gnt%0d", i), b_gnt, 1);
      end else begin
        idle();
      end
      step();
      if (i >= 2) begin
        check($sformatf("b2b_rv%0d", i - 2), {a_rvalid, b_rvalid}, 2'b01);
        check($sformatf("b2b_rd%0d", i - 2), b_rdata, 32'h100 + i - 2);
      end
    end
    step();
    check("b2b_done", b_rvalid, 0);

    // ---------------- reset mid-read ----------------
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_a(1'b1, 1'b0, 8'h12, 32'h0, 4'h0);
    step();
    idle();
    step();
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 8'h12, 32'h0, 4'h0);
    drive_b(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
    #1 check("midrst_gnts", {a_gnt, b_gnt}, 2'b00);
    step();
    check("midrst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("midrst_post_rv%0d", i), a_rvalid, 0);
    end
    check("midrst_rdata", a_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Two-requester arbiter and sequencer for the RW port (port 0) of the 32x256 OpenRAM SRAM macro with byte write masks. It accepts single-word read and write requests from requesters A and B over a request/grant handshake. It drives the macro's `csb0`/`web0`/`wmask0`/`addr0`/`din0` from registers and returns read data to the requester that issued the read, with a fixed latency. The macro's `clk0` is tied to this block's `clk`; port 1 of the macro is not handled here.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word address width.
- `DATA_WIDTH`, default 32: word width.
- `NUM_WMASKS`, default 4: byte-lane write-mask bits (`DATA_WIDTH/8`).

Ports:
- `clk` input 1: single clock, also drives the macro's `clk0`.
- `rst_n` input 1: asynchronous, active-low reset.
- `a_req`, `b_req` input 1: request valid.
- `a_we`, `b_we` input 1: 1 = write, 0 = read.
- `a_wmask`, `b_wmask` input NUM_WMASKS: byte enables (writes only).
- `a_addr`, `b_addr` input ADDR_WIDTH: word address.
- `a_wdata`, `b_wdata` input DATA_WIDTH: write data.
- `a_gnt`, `b_gnt` output 1: combinational grant; the request is accepted in a cycle where `req & gnt`.
- `a_rvalid`, `b_rvalid` output 1: one-cycle read-data strobe.
- `a_rdata`, `b_rdata` output DATA_WIDTH: read data.
- `sram_csb0` output 1: macro chip select, active low, registered.
- `sram_web0` output 1: macro write enable, active low, registered.
- `sram_wmask0` output NUM_WMASKS: macro write mask, registered.
- `sram_addr0` output ADDR_WIDTH: macro address, registered.
- `sram_din0` output DATA_WIDTH: macro write data, registered.
- `sram_dout0` input DATA_WIDTH: macro read data.

## Operation
- Each cycle, at most one of `a_gnt`/`b_gnt` is 1. A gnt is asserted only when the matching req is 1 and `rst_n`=1.
- Arbitration (default round-robin):
  - If only one requester has req=1, it wins.
  - If both have req=1, the requester not granted most recently wins.
  - A 1-bit `last` register updates only on an accepted request.
  - After reset, `last`=B, so A wins the first tie.
- When a request is accepted at edge T, the command registers load at that edge:
  - `sram_csb0`=0.
  - `sram_web0`=`~we`.
  - `sram_addr0`, `sram_din0` and `sram_wmask0` load from the winning requester.
  - For a read, `sram_wmask0` loads 0.
- In a cycle with no accepted request:
  - `sram_csb0`=1 and `sram_web0`=1.
  - `sram_addr0`, `sram_din0` and `sram_wmask0` hold their last values.
- Reads use a 2-stage response pipeline. Each stage holds `{valid, owner}`:
  - Stage 1 is set at acceptance.
  - Stage 2 is loaded at the next edge, when the macro samples the command.
  - At the following edge, `sram_dout0` (launched by the macro on the falling edge) is registered into the owner's `rdata`, and the owner's `rvalid` is pulsed.
- Writes produce no response.
- `x_rdata` holds its value between strobes. Only the owner's `rdata` updates.
- Read-after-write to the same address in the next accepted slot returns the new data. The macro writes on the falling edge of the write's cycle, before the read's sampling edge. No forwarding logic is required.
- A write with all-zero `wmask` is issued to the macro unchanged and leaves memory unmodified.

## Timing
- Request accepted at edge T (`req & gnt` in cycle T-1→T):
  - Command visible on `sram_*` during cycle T→T+1.
  - Macro samples the command at edge T+1.
  - Read data is captured into `x_rdata` and `x_rvalid`=1 at edge T+2.
- Read latency: accept edge to `rvalid` = 2 edges.
- Throughput: one accepted request per cycle, mixed reads and writes, back-to-back with no bubbles. Both rvalids can never be set in the same cycle.
- Reset values (async on `rst_n`=0):
  - `sram_csb0`=1, `sram_web0`=1.
  - `sram_wmask0`=0, `sram_addr0`=0, `sram_din0`=0.
  - `a_rvalid`=`b_rvalid`=0, `a_rdata`=`b_rdata`=0.
  - Pipeline valids=0, `last`=B.
- Gnts are 0 while `rst_n`=0.
- Reset mid-operation: in-flight reads are dropped and no rvalid is generated for them. A write already sampled by the macro may complete.
- After reset deassertion, the first acceptance is possible at the first rising edge with `rst_n`=1.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined:
  - A has strict priority: `b_gnt` = `b_req & ~a_req`.
  - The `last` register is not implemented.
- `SRAM_ARB_FIXED_PRIO_EN` undefined: round-robin as described above.

## Test plan
- Reset: `rst_n`=0 with both req=1 → gnts=0, `sram_csb0`=1, `sram_web0`=1, all rvalids=0. After release, A is granted first.
- Single write then read:
  - A writes addr 0x12, data 0xDEADBEEF, wmask 0xF, then reads 0x12.
  - Required: `a_rvalid` two edges after the read is accepted, `a_rdata`=0xDEADBEEF, `b_rvalid` never set.
- Byte mask:
  - Write 0x11223344 with mask 0xF to addr 5, then write 0xAABBCCDD with mask 0x5, then read addr 5.
  - Required: rdata = 0x11BB33DD.
- Contention (default build): both req=1 for 6 cycles → gnt alternates A,B,A,B,A,B. Every read's rvalid and rdata go to its issuer only. With the macro defined, A is granted in all 6 cycles.
- Back-to-back: B issues 8 consecutive reads of addr 0..7, pre-loaded with value = addr + 0x100 → 8 consecutive `b_rvalid` pulses with data 0x100..0x107 in order.
- Reset mid-read: accept an A read, then assert `rst_n`=0 one cycle later → no `a_rvalid` after reset release, `a_rdata`=0.
